// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

    localparam int ADDR_W_DEF  = 64;
    localparam int DATA_W_DEF  = 64;
    localparam int MEM_LAT_DEF = 1;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin winner select with a debug priority lock.
module rr_pick2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       lock,
    output logic       win,
    output logic       any
);

    // Lock holds debug priority and keeps the CPU waiting; otherwise
    // a tie goes to the port that was not granted last.
    always_comb begin
        win = PORT_CPU;
        any = 1'b0;
        if (lock && (last == PORT_DBG)) begin
            win = PORT_DBG;
            any = req[PORT_DBG];
        end else if (req[PORT_CPU] && req[PORT_DBG]) begin
            win = ~last;
            any = 1'b1;
        end else if (req[PORT_DBG]) begin
            win = PORT_DBG;
            any = 1'b1;
        end else if (req[PORT_CPU]) begin
            win = PORT_CPU;
            any = 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data memory between the CPU load/store port and the debug port.
//
// state  | meaning
// IDLE   | sample requests, pick a winner, latch its payload
// ACCESS | memory strobe and grant for one cycle
// WAIT   | read latency countdown, address and read strobe held
// RESP   | read data valid pulse to the winner
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int MEM_LAT = MEM_LAT_DEF
) (
    input  logic              CLK,
    input  logic              resetl,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    input  logic              d_lock,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    // Countdown load value; only used when MEM_LAT > 0.
    localparam logic [1:0] LAT_LOAD = 2'(MEM_LAT - 1);

    arb_state_t state;
    logic [1:0] lat_cnt;
    logic       owner;
    logic       last;
    logic       win;
    logic       any;
    logic       rsp_now;

    rr_pick2 u_pick (
        .req  ({d_req, c_req}),
        .last (last),
        .lock (d_lock),
        .win  (win),
        .any  (any)
    );

    // Read data is captured on the edge that ends the latency window.
    assign rsp_now = ((state == ACCESS) && mem_read && (MEM_LAT == 0)) ||
                     ((state == WAIT) && (lat_cnt == 2'd0));

    // Arbitration FSM with registered memory controls and handshake pulses.
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state     <= IDLE;
            lat_cnt   <= 2'd0;
            owner     <= PORT_CPU;
            last      <= PORT_DBG;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            c_gnt     <= 1'b0;
            d_gnt     <= 1'b0;
            c_rvalid  <= 1'b0;
            d_rvalid  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            c_gnt    <= 1'b0;
            d_gnt    <= 1'b0;
            c_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (any) begin
                        owner <= win;
                        last  <= win;
                        busy  <= 1'b1;
                        state <= ACCESS;
                        if (win == PORT_DBG) begin
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            mem_write <= d_we;
                            mem_read  <= ~d_we;
                            d_gnt     <= 1'b1;
                        end else begin
                            mem_addr  <= c_addr;
                            mem_wdata <= c_wdata;
                            mem_write <= c_we;
                            mem_read  <= ~c_we;
                            c_gnt     <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    mem_write <= 1'b0;
                    if (mem_write) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (MEM_LAT > 0) begin
                        lat_cnt <= LAT_LOAD;
                        state   <= WAIT;
                    end else begin
                        mem_read <= 1'b0;
                        c_rvalid <= (owner == PORT_CPU);
                        d_rvalid <= (owner == PORT_DBG);
                        state    <= RESP;
                    end
                end
                WAIT: begin
                    if (lat_cnt == 2'd0) begin
                        mem_read <= 1'b0;
                        c_rvalid <= (owner == PORT_CPU);
                        d_rvalid <= (owner == PORT_DBG);
                        state    <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Only the winner's read data register is ever written.
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            c_rdata <= '0;
            d_rdata <= '0;
        end else if (rsp_now) begin
            if (owner == PORT_DBG) d_rdata <= mem_rdata;
            else                   c_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: u1 uses MEM_LAT=1, u3 uses MEM_LAT=3.
module tb_dmem_arbiter;

    logic        CLK = 1'b0;
    logic        resetl1, resetl3;
    logic        c_req, c_we, d_req, d_we, d_lock;
    logic [63:0] c_addr, c_wdata, d_addr, d_wdata, mem_rdata;

    logic        c_gnt1, c_rvalid1, d_gnt1, d_rvalid1, mem_read1, mem_write1, busy1;
    logic [63:0] c_rdata1, d_rdata1, mem_addr1, mem_wdata1;
    logic        c_gnt3, c_rvalid3, d_gnt3, d_rvalid3, mem_read3, mem_write3, busy3;
    logic [63:0] c_rdata3, d_rdata3, mem_addr3, mem_wdata3;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 CLK = ~CLK;

    dmem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(1)) u1 (
        .CLK(CLK), .resetl(resetl1),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt1), .c_rvalid(c_rvalid1), .c_rdata(c_rdata1),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
        .d_lock(d_lock),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_read(mem_read1), .mem_write(mem_write1),
        .mem_rdata(mem_rdata), .busy(busy1)
    );

    dmem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(3)) u3 (
        .CLK(CLK), .resetl(resetl3),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt3), .c_rvalid(c_rvalid3), .c_rdata(c_rdata3),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt3), .d_rvalid(d_rvalid3), .d_rdata(d_rdata3),
        .d_lock(d_lock),
        .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
        .mem_read(mem_read3), .mem_write(mem_write3),
        .mem_rdata(mem_rdata), .busy(busy3)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else
            n_pass++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ngnt_d, nrv_d, c_gnt_t, ncg, nbad;

        resetl1 = 1'b0; resetl3 = 1'b0;
        c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        d_lock = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge CLK);

        // reset values
        check("rst_busy", busy1, 0);
        check("rst_mem_ctl", {mem_read1, mem_write1}, 0);
        check("rst_pulses", {c_gnt1, d_gnt1, c_rvalid1, d_rvalid1}, 0);
        check("rst_rdata", c_rdata1 | d_rdata1, 0);
        check("rst_mem_bus", mem_addr1 | mem_wdata1, 0);
        resetl1 = 1'b1;

        // single CPU read, MEM_LAT=1
        @(negedge CLK);
        c_req = 1'b1; c_we = 1'b0; c_addr = 64'h40; mem_rdata = 64'hDEAD_BEEF;
        @(negedge CLK);
        check("t1_gnt", c_gnt1, 1);
        check("t1_rd_a", mem_read1, 1);
        check("t1_addr", mem_addr1, 64'h40);
        check("t1_no_rv", c_rvalid1, 0);
        c_req = 1'b0;
        @(negedge CLK);
        check("t1_rd_b", mem_read1, 1);
        check("t1_gnt_pulse", c_gnt1, 0);
        @(negedge CLK);
        check("t1_rvalid", c_rvalid1, 1);
        check("t1_rdata", c_rdata1, 64'hDEAD_BEEF);
        check("t1_rd_off", mem_read1, 0);
        check("t1_d_rdata", d_rdata1, 0);
        @(negedge CLK);
        check("t1_idle", busy1, 0);
        check("t1_rv_pulse", c_rvalid1, 0);
        check("t1_hold", c_rdata1, 64'hDEAD_BEEF);

        // simultaneous writes after reset: CPU first, then debug
        resetl1 = 1'b0;
        @(negedge CLK);
        resetl1 = 1'b1;
        c_req = 1'b1; c_we = 1'b1; c_addr = 64'h100; c_wdata = 64'h11;
        d_req = 1'b1; d_we = 1'b1; d_addr = 64'h200; d_wdata = 64'h22;
        @(negedge CLK);
        check("t2_gnt_cpu", {c_gnt1, d_gnt1}, 2'b10);
        check("t2_wr_cpu", {mem_write1, mem_read1}, 2'b10);
        check("t2_addr_cpu", mem_addr1, 64'h100);
        check("t2_data_cpu", mem_wdata1, 64'h11);
        c_req = 1'b0;
        @(negedge CLK);
        check("t2_gap_wr", mem_write1, 0);
        check("t2_gap_busy", busy1, 0);
        @(negedge CLK);
        check("t2_gnt_dbg", {c_gnt1, d_gnt1}, 2'b01);
        check("t2_wr_dbg", {mem_write1, mem_read1}, 2'b10);
        check("t2_addr_dbg", mem_addr1, 64'h200);
        check("t2_data_dbg", mem_wdata1, 64'h22);
        d_req = 1'b0;
        @(negedge CLK);
        check("t2_end_wr", mem_write1, 0);
        check("t2_end_gnt", {c_gnt1, d_gnt1}, 2'b00);

        // continuous requests on both ports: 8 alternating write ops
        c_req = 1'b1; d_req = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge CLK);
            if (k % 2 == 1) begin
                check($sformatf("t3_gnt%0d", k), {c_gnt1, d_gnt1},
                      (((k - 1) / 2) % 2 == 0) ? 2'b10 : 2'b01);
                check($sformatf("t3_busy%0d", k), busy1, 1);
            end else begin
                check($sformatf("t3_gnt%0d", k), {c_gnt1, d_gnt1}, 2'b00);
                check($sformatf("t3_busy%0d", k), busy1, 0);
            end
            if (k == 15) begin
                c_req = 1'b0; d_req = 1'b0;
            end
        end

        // debug lock: four debug reads before the CPU gets in
        c_we = 1'b0; c_addr = 64'h80;
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h300; d_lock = 1'b1; mem_rdata = 64'h55;
        ngnt_d = 0; nrv_d = 0; c_gnt_t = 0;
        for (int t = 1; t <= 40 && c_gnt_t == 0; t++) begin
            @(negedge CLK);
            if (d_rvalid1) nrv_d++;
            if (c_gnt1) begin
                c_gnt_t = t;
                c_req = 1'b0;
                mem_rdata = 64'h77;
            end
            if (d_gnt1) begin
                ngnt_d++;
                if (ngnt_d == 1) c_req = 1'b1;
                if (ngnt_d == 4) begin
                    d_lock = 1'b0; d_req = 1'b0;
                end
            end
        end
        check("t4_dbg_gnts", ngnt_d, 4);
        check("t4_cgnt_cycle", c_gnt_t, 17);
        check("t4_dbg_rvalids", nrv_d, 4);
        check("t4_d_rdata", d_rdata1, 64'h55);
        repeat (2) @(negedge CLK);
        check("t4_c_rvalid", c_rvalid1, 1);
        check("t4_c_rdata", c_rdata1, 64'h77);
        @(negedge CLK);

        // CPU request pulsed only during a debug ACCESS is withdrawn
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h600; mem_rdata = 64'hABC;
        ncg = 0;
        for (int t = 1; t <= 8; t++) begin
            @(negedge CLK);
            if (c_gnt1) ncg++;
            if (t == 1) begin
                check("t6_dgnt", d_gnt1, 1);
                d_req = 1'b0;
                c_req = 1'b1;
            end
            if (t == 2) c_req = 1'b0;
        end
        check("t6_no_cgnt", ncg, 0);
        check("t6_d_rdata", d_rdata1, 64'hABC);
        check("t6_c_rdata", c_rdata1, 64'h77);
        check("t6_idle", busy1, 0);

        // async reset during WAIT, MEM_LAT=3
        resetl1 = 1'b0;
        resetl3 = 1'b1;
        @(negedge CLK);
        c_req = 1'b1; c_we = 1'b0; c_addr = 64'h500; mem_rdata = 64'h1234;
        @(negedge CLK);
        check("t5_gnt", c_gnt3, 1);
        c_req = 1'b0;
        @(negedge CLK);
        check("t5_wait_rd", mem_read3, 1);
        @(negedge CLK);
        check("t5_wait_rd2", mem_read3, 1);
        check("t5_wait_busy", busy3, 1);
        #1 resetl3 = 1'b0;
        #1;
        check("t5_async_rd", mem_read3, 0);
        check("t5_async_busy", busy3, 0);
        repeat (2) @(negedge CLK);
        resetl3 = 1'b1;
        nbad = 0;
        for (int t = 1; t <= 6; t++) begin
            @(negedge CLK);
            if (c_rvalid3 || d_rvalid3 || c_gnt3 || d_gnt3) nbad++;
        end
        check("t5_no_rvalid", nbad, 0);
        c_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
        @(negedge CLK);
        check("t5_tie_cpu", {c_gnt3, d_gnt3}, 2'b10);
        c_req = 1'b0; d_req = 1'b0;
        check("t5_c_rdata", c_rdata3, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single data memory between the processor's load/store path (CPU port) and a debug/program-loader port. It accepts one request at a time, drives the memory control and address lines from registers, waits the configured read latency, and returns read data to the winning requester. It sits between the `singlecycle` datapath, the loader, and `DataMemory`. It lets programs and data be loaded or inspected while the core runs, with the core stalled on `c_gnt`.

## Interface
- `ADDR_W`, 64, address width
- `DATA_W`, 64, data width
- `MEM_LAT`, 1, memory read latency in cycles after the ACCESS cycle (legal 0..3)

- `CLK`  in  1  single clock; all state updates on rising edge
- `resetl`  in  1  asynchronous, active-low reset
- `c_req`  in  1  CPU request; held with payload until `c_gnt`
- `c_we`  in  1  CPU write (1) / read (0)
- `c_addr`  in  ADDR_W  CPU address
- `c_wdata`  in  DATA_W  CPU write data
- `c_gnt`  out  1  one-cycle pulse: CPU request accepted
- `c_rvalid`  out  1  one-cycle pulse: `c_rdata` valid
- `c_rdata`  out  DATA_W  CPU read data, held until next CPU read response
- `d_req`, `d_we`, `d_addr`, `d_wdata`, `d_gnt`, `d_rvalid`, `d_rdata`: same as the `c_` ports, for the debug port
- `d_lock`  in  1  debug keeps priority while high after a debug grant
- `mem_addr`  out  ADDR_W  memory address (registered)
- `mem_wdata`  out  DATA_W  memory write data (registered)
- `mem_read`  out  1  memory read enable
- `mem_write`  out  1  memory write enable
- `mem_rdata`  in  DATA_W  memory read data
- `busy`  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, ACCESS, WAIT, RESP.
- **IDLE**
  - If any `req` is high, pick a winner, latch its `we`/`addr`/`wdata` and go to ACCESS.
  - Otherwise stay in IDLE.
- **ACCESS** (exactly 1 cycle)
  - `gnt` of the winner is high.
  - `mem_addr`/`mem_wdata` carry the latched values.
  - `mem_write` is high if the access is a write; `mem_read` is high if it is a read.
  - Write: next state is IDLE.
  - Read: next state is WAIT if `MEM_LAT > 0`, else RESP.
- **WAIT**
  - Lasts `MEM_LAT` cycles, counted by a 2-bit down-counter.
  - `mem_read` and `mem_addr` stay held.
  - `mem_rdata` is sampled into the winner's `rdata` register at the edge ending the last WAIT cycle, or the edge ending ACCESS when `MEM_LAT = 0`.
- **RESP** (1 cycle)
  - The winner's `rvalid` is high; next state is IDLE.
- **Arbitration**
  - 2-way round robin with a `last` pointer, updated on every grant.
  - A single requester always wins.
  - On a tie, the port not granted last wins.
  - If `d_lock` is high and `last` = debug, debug wins regardless and the CPU waits.
- A `req` dropped before its grant is treated as withdrawn; nothing is accessed.
- Request lines are sampled only in IDLE. A request asserted during ACCESS/WAIT/RESP is considered at the next IDLE.
- Addresses are passed through unchanged, with no alignment check.
- The non-winning port's `rdata` is never modified.

## Timing
- Reset values:
  - all outputs 0, including `rdata` registers
  - state IDLE
  - `last` = debug, so the CPU wins the first tie
- Reset is asynchronous. Asserting `resetl` mid-operation drops `mem_write`/`mem_read` immediately, and no `gnt` or `rvalid` follows.
- Latency, from the IDLE edge with `req` high:
  - `gnt` rises 1 cycle later.
  - Write: 2 cycles per op (IDLE + ACCESS).
  - Read: `rvalid` rises `2+MEM_LAT` cycles after the request is sampled; 3+`MEM_LAT` cycles per op including the return to IDLE.
- At least one IDLE cycle separates consecutive accesses; this is required, not an optimisation target.
- `gnt` and `rvalid` are registered outputs and never high in the same cycle.

## Structure
- Package `dmem_arb_pkg`:
  - state enum (IDLE/ACCESS/WAIT/RESP)
  - port index constants `PORT_CPU = 0`, `PORT_DBG = 1`
  - default widths
- Sub-module `rr_pick2`: combinational 2-way round-robin winner select.
  - inputs: `req[1:0]`, `last`, `lock`
  - outputs: `win`, `any`
- Everything else lives in `dmem_arbiter`: FSM, latency counter, payload and `rdata` registers.

## Test plan
- CPU read only, `MEM_LAT = 1`, `c_addr = 0x40`, memory returns `0xDEAD_BEEF`:
  - `c_gnt` 1 cycle after request
  - `mem_read` high for 2 cycles
  - `c_rvalid` with `c_rdata = 0xDEAD_BEEF` 3 cycles after request
- Both ports write in the same IDLE cycle after reset:
  - CPU granted first, then debug
  - exactly one `mem_write` pulse each, with correct address and data
- Alternating continuous requests on both ports for 8 ops:
  - grants alternate CPU/DBG
  - `busy` drops for exactly 1 cycle between ops
- `d_lock = 1`, debug issues 4 back-to-back reads while `c_req` is held:
  - all 4 debug grants occur before `c_gnt`
  - `c_gnt` follows on the first IDLE after `d_lock` falls
- Reset mid-op: assert `resetl = 0` during WAIT (`MEM_LAT = 3`):
  - `mem_read` and `busy` go to 0 asynchronously
  - no `rvalid`
  - first tie after release goes to the CPU
- `c_req` pulses 1 cycle during ACCESS of a debug op, then drops:
  - no CPU grant
  - `c_rdata` unchanged
